// File: rtl/clk_div_prog.sv
// -----------------------------------------------------------------------------
// clk_div_prog
//   Programmable synchronous clock divider. A single counter on clk_in
//   produces a registered divided clock (low for ceil(N/2) cycles, high for
//   floor(N/2) cycles) and a one-cycle tick on the last cycle of each period.
//
//   Optional feature macro: CLK_DIV_PROG_SYNC_LOAD_EN
//     defined   - a loaded divisor is held pending and applied at the period
//                 boundary (or at once when stopped or disabled), so clk_out
//                 never shows a truncated period.
//     undefined - div_load applies div_in on the same edge; pend is tied to 0.
//
// Parameters
//   WIDTH    width of the divisor and the counter
//   RST_DIV  divisor loaded on reset (must fit in WIDTH bits)
//
// Ports
//   clk_in    system clock, all logic on its rising edge
//   rst       synchronous active-high reset, overrides every other input
//   en        count enable
//   div_in    new divisor N
//   div_load  one-cycle strobe capturing div_in
//   clk_out   divided clock (registered)
//   tick      one-cycle pulse on the last cycle of each period (registered)
//   div_cur   divisor currently in effect
//   pend      a loaded divisor is waiting to be applied
// -----------------------------------------------------------------------------
module clk_div_prog #(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned RST_DIV = 2
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] div_in,
  input  logic             div_load,
  output logic             clk_out,
  output logic             tick,
  output logic [WIDTH-1:0] div_cur,
  output logic             pend
);

  localparam logic [WIDTH-1:0] RST_DIV_W = WIDTH'(RST_DIV);
  localparam logic [WIDTH-1:0] ONE_W     = WIDTH'(1);
  localparam logic [WIDTH-1:0] TWO_W     = WIDTH'(2);

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] div_cur_q, div_cur_d;
  logic             clk_out_q, clk_out_d;
  logic             tick_q, tick_d;

  // Counting datapath for the divisor in effect.
  logic [WIDTH-1:0] n_m1;       // N-1, WIDTH bits
  logic [WIDTH:0]   half;       // (N+1)/2 in WIDTH+1 bits so N=2^WIDTH-1 fits
  logic [WIDTH-1:0] cnt_wrap;   // counter successor with wrap at N-1
  logic             at_last;    // counter sits on the last cycle of the period

  always_comb begin
    n_m1     = div_cur_q - ONE_W;
    half     = ({1'b0, div_cur_q} + (WIDTH+1)'(1)) >> 1;
    at_last  = (cnt_q == n_m1);
    cnt_wrap = at_last ? '0 : cnt_q + ONE_W;
  end

  // Next state when no divisor is applied on this edge.
  logic [WIDTH-1:0] cnt_run;
  logic             clk_run;
  logic             tick_run;

  always_comb begin
    cnt_run  = cnt_q;
    clk_run  = clk_out_q;
    tick_run = 1'b0;
    if (div_cur_q == '0) begin
      cnt_run  = '0;
      clk_run  = 1'b0;
      tick_run = 1'b0;
    end else if (div_cur_q == ONE_W) begin
      cnt_run  = '0;
      clk_run  = 1'b0;
      tick_run = en;
    end else if (en) begin
      cnt_run  = cnt_wrap;
      clk_run  = ({1'b0, cnt_wrap} >= half);
      tick_run = (cnt_wrap == n_m1);
    end
  end

`ifdef CLK_DIV_PROG_SYNC_LOAD_EN

  logic [WIDTH-1:0] div_nxt_q, div_nxt_d;
  logic             pend_q, pend_d;
  logic             apply;

  always_comb begin
    apply     = pend_q && ((en && at_last) || (div_cur_q < TWO_W) || !en);
    cnt_d     = cnt_run;
    clk_out_d = clk_run;
    tick_d    = tick_run;
    div_cur_d = div_cur_q;
    div_nxt_d = div_nxt_q;
    pend_d    = pend_q;
    if (apply) begin
      div_cur_d = div_nxt_q;
      cnt_d     = '0;
      clk_out_d = 1'b0;
      tick_d    = 1'b0;
      pend_d    = 1'b0;
    end
    // A load coinciding with an apply becomes the next pending value, while
    // the previous div_nxt is the one applied above.
    if (div_load) begin
      div_nxt_d = div_in;
      pend_d    = 1'b1;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      div_nxt_q <= RST_DIV_W;
      pend_q    <= 1'b0;
    end else begin
      div_nxt_q <= div_nxt_d;
      pend_q    <= pend_d;
    end
  end

  assign pend = pend_q;

`else

  always_comb begin
    cnt_d     = cnt_run;
    clk_out_d = clk_run;
    tick_d    = tick_run;
    div_cur_d = div_cur_q;
    if (div_load) begin
      div_cur_d = div_in;
      cnt_d     = '0;
      clk_out_d = 1'b0;
      tick_d    = 1'b0;
    end
  end

  assign pend = 1'b0;

`endif

  always_ff @(posedge clk_in) begin
    if (rst) begin
      cnt_q     <= '0;
      div_cur_q <= RST_DIV_W;
      clk_out_q <= 1'b0;
      tick_q    <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      div_cur_q <= div_cur_d;
      clk_out_q <= clk_out_d;
      tick_q    <= tick_d;
    end
  end

  assign clk_out = clk_out_q;
  assign tick    = tick_q;
  assign div_cur = div_cur_q;

endmodule

// File: tb/tb_clk_div_prog.sv
// -----------------------------------------------------------------------------
// tb_clk_div_prog
//   Directed bench for clk_div_prog (WIDTH=8, RST_DIV=2). Expected waveforms
//   are hand-derived low/high cycle counts per divisor. Honours
//   CLK_DIV_PROG_SYNC_LOAD_EN for the load-timing sections.
// -----------------------------------------------------------------------------
module tb_clk_div_prog;

  logic       clk_in = 1'b0;
  logic       rst;
  logic       en;
  logic [7:0] div_in;
  logic       div_load;
  logic       clk_out;
  logic       tick;
  logic [7:0] div_cur;
  logic       pend;

  int unsigned checks   = 0;
  int unsigned failures = 0;

  clk_div_prog #(
    .WIDTH  (8),
    .RST_DIV(2)
  ) dut (
    .clk_in  (clk_in),
    .rst     (rst),
    .en      (en),
    .div_in  (div_in),
    .div_load(div_load),
    .clk_out (clk_out),
    .tick    (tick),
    .div_cur (div_cur),
    .pend    (pend)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance one edge; outputs are then stable for the new cycle.
  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  // Starting at phase 0 with en=1: lo low cycles, then high, tick on the last.
  task automatic chk_period(input string tag, input int unsigned n, input int unsigned lo);
    for (int unsigned p = 0; p < n; p++) begin
      chk({tag, "_clk"}, 32'(clk_out), 32'(p >= lo));
      chk({tag, "_tick"}, 32'(tick), 32'(p == n - 1));
      step();
    end
  endtask

  // Load a divisor and wait (bounded) until it is in effect; leaves the
  // bench at phase 0 of the new divisor.
  task automatic load_div(input string tag, input logic [7:0] n);
    int unsigned k;
    div_in   = n;
    div_load = 1'b1;
    step();
    div_load = 1'b0;
    k = 0;
    while (!(div_cur == n && pend == 1'b0) && k < 300) begin
      step();
      k++;
    end
    chk({tag, "_applied"}, 32'(div_cur == n && pend == 1'b0), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst      = 1'b1;
    en       = 1'b0;
    div_in   = '0;
    div_load = 1'b0;
    step();
    step();
    chk("rst_clk", 32'(clk_out), 32'd0);
    chk("rst_tick", 32'(tick), 32'd0);
    chk("rst_div", 32'(div_cur), 32'd2);
    chk("rst_pend", 32'(pend), 32'd0);

    // N=2 out of reset: 0,1,0,1...
    rst = 1'b0;
    en  = 1'b1;
    for (int unsigned i = 0; i < 8; i++) begin
      chk("n2_clk", 32'(clk_out), 32'(i % 2));
      chk("n2_tick", 32'(tick), 32'(i % 2));
      step();
    end
    chk("n2_div", 32'(div_cur), 32'd2);

    // Load N=5 at phase 0.
    div_in   = 8'd5;
    div_load = 1'b1;
    step();
    div_load = 1'b0;
`ifdef CLK_DIV_PROG_SYNC_LOAD_EN
    chk("n5_pend", 32'(pend), 32'd1);
    chk("n5_old_div", 32'(div_cur), 32'd2);
    chk("n5_old_clk", 32'(clk_out), 32'd1);
    chk("n5_old_tick", 32'(tick), 32'd1);
    step();
`endif
    chk("n5_div", 32'(div_cur), 32'd5);
    chk("n5_pend0", 32'(pend), 32'd0);
    chk_period("n5a", 5, 3);
    chk_period("n5b", 5, 3);

    // Freeze at cnt=3 (clk high) for 3 cycles, then resume.
    for (int unsigned p = 0; p < 3; p++) begin
      chk("pre_clk", 32'(clk_out), 32'd0);
      chk("pre_tick", 32'(tick), 32'd0);
      step();
    end
    chk("frz_in_clk", 32'(clk_out), 32'd1);
    en = 1'b0;
    for (int unsigned p = 0; p < 3; p++) begin
      step();
      chk("frz_clk", 32'(clk_out), 32'd1);
      chk("frz_tick", 32'(tick), 32'd0);
    end
    en = 1'b1;
    step();
    chk("res_clk", 32'(clk_out), 32'd1);
    chk("res_tick", 32'(tick), 32'd1);
    step();
    chk_period("n5c", 5, 3);

    // N=6, then load N=3 while cnt=1.
    load_div("n6", 8'd6);
    chk("n6_p0_clk", 32'(clk_out), 32'd0);
    step();
    div_in   = 8'd3;
    div_load = 1'b1;
    step();
    div_load = 1'b0;
`ifdef CLK_DIV_PROG_SYNC_LOAD_EN
    for (int unsigned p = 2; p < 6; p++) begin
      chk("n6_clk", 32'(clk_out), 32'(p >= 3));
      chk("n6_tick", 32'(tick), 32'(p == 5));
      chk("n6_pend", 32'(pend), 32'd1);
      chk("n6_div", 32'(div_cur), 32'd6);
      step();
    end
`endif
    chk("n3_div", 32'(div_cur), 32'd3);
    chk("n3_pend", 32'(pend), 32'd0);
    chk_period("n3a", 3, 2);
    chk_period("n3b", 3, 2);

    // N=7, reset at cnt=5 with a simultaneous (ignored) load.
    load_div("n7", 8'd7);
    for (int unsigned p = 0; p < 5; p++) begin
      chk("n7_clk", 32'(clk_out), 32'(p >= 4));
      step();
    end
    chk("n7_c5_clk", 32'(clk_out), 32'd1);
    rst      = 1'b1;
    div_in   = 8'd9;
    div_load = 1'b1;
    step();
    rst      = 1'b0;
    div_load = 1'b0;
    chk("mrst_clk", 32'(clk_out), 32'd0);
    chk("mrst_tick", 32'(tick), 32'd0);
    chk("mrst_div", 32'(div_cur), 32'd2);
    chk("mrst_pend", 32'(pend), 32'd0);
    chk_period("post_rst", 2, 1);
    chk("post_rst_div", 32'(div_cur), 32'd2);

    // N=255: 128 low, 127 high.
    load_div("n255", 8'd255);
    chk_period("n255a", 255, 128);
    chk_period("n255b", 255, 128);

    // N=1: tick every enabled cycle, clk_out low.
    load_div("n1", 8'd1);
    chk("n1_first_tick", 32'(tick), 32'd0);
    for (int unsigned p = 0; p < 4; p++) begin
      step();
      chk("n1_tick", 32'(tick), 32'd1);
      chk("n1_clk", 32'(clk_out), 32'd0);
    end
    en = 1'b0;
    step();
    chk("n1_dis_tick", 32'(tick), 32'd0);
    en = 1'b1;
    step();
    chk("n1_reen_tick", 32'(tick), 32'd1);

    // N=0: stopped.
    load_div("n0", 8'd0);
    for (int unsigned p = 0; p < 4; p++) begin
      chk("n0_clk", 32'(clk_out), 32'd0);
      chk("n0_tick", 32'(tick), 32'd0);
      chk("n0_div", 32'(div_cur), 32'd0);
      chk("n0_pend", 32'(pend), 32'd0);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/clk_div_prog.md
# clk_div_prog

Programmable, fully synchronous clock divider: successor to the fixed ripple divide-by-2^k chain. A single counter in the `clk_in` domain replaces the cascade of toggle stages. It produces a divided clock `clk_out` for any divisor N from 2 to 2^WIDTH-1, plus a one-cycle `tick` enable for downstream logic that stays on `clk_in`. The divisor is reloadable at runtime, so display-scan, debounce and UART-baud consumers can share one block type.

## Interface
- `WIDTH`, 8: width of divisor and counter.
- `RST_DIV`, 2: divisor loaded on reset. Must fit in `WIDTH` bits.
- `clk_in` in 1: system clock. All logic is on its rising edge.
- `rst` in 1: reset, synchronous, active-high. Overrides every other input.
- `en` in 1: count enable.
- `div_in` in WIDTH: new divisor N.
- `div_load` in 1: one-cycle strobe to capture `div_in`.
- `clk_out` out 1: divided clock, registered.
- `tick` out 1: one-cycle pulse on the last cycle of each period, registered.
- `div_cur` out WIDTH: divisor currently in effect.
- `pend` out 1: a loaded divisor is waiting to be applied. Constant 0 when the macro is off.

## Operation
- State: `cnt` (WIDTH bits), `div_cur`, `div_nxt`, `pend`, plus the `clk_out` and `tick` registers.
- Reset values:
  - `cnt`=0, `clk_out`=0, `tick`=0, `pend`=0.
  - `div_cur`=`RST_DIV`, `div_nxt`=`RST_DIV`.
- Counting, with N=`div_cur` ≥ 2 and `en`=1:
  - `cnt_next` = (`cnt`==N-1) ? 0 : `cnt`+1.
  - `clk_out` <= (`cnt_next` ≥ (N+1)/2), using integer division.
  - `tick` <= (`cnt_next`==N-1).
  - Result: `clk_out` is low for ceil(N/2) cycles and high for floor(N/2) cycles, with period N.
- `en`=0: `cnt` and `clk_out` hold their values and `tick` <= 0. Counting resumes from the held `cnt` when `en` returns to 1.
- N=0 (stopped): `cnt`=0, `clk_out`=0, `tick`=0.
- N=1: `cnt`=0, `clk_out`=0, and `tick`=`en` registered, i.e. a pulse every enabled cycle.
- Arithmetic:
  - N-1 is computed in WIDTH bits.
  - (N+1)/2 is computed in WIDTH+1 bits, so N=2^WIDTH-1 does not overflow.
  - `cnt` never exceeds N-1.
- Divisor load behaviour depends on the macro; see Configuration.
- Applying a divisor always means:
  - `div_cur` <= new value.
  - `cnt` <= 0, `clk_out` <= 0, `tick` <= 0.
  - The first full period of the new N starts on the next edge.

## Timing
- All outputs are registered. There is no combinational path from input to output.
- `tick` coincides with the last cycle of the period and with the final high cycle of `clk_out`.
- Example, N=2 after reset with `en`=1:
  - `clk_out` = 0,1,0,1… toggles every cycle.
  - `tick` = 0,1,0,1…
- Example, N=3: `clk_out` = 0,0,1 repeating; `tick` high on the third cycle of each period.
- `rst` mid-period: all outputs take their reset values on that edge. `div_cur` returns to `RST_DIV` and any pending load is discarded.
- `div_load` is ignored on any edge where `rst`=1.

## Configuration
- Macro: `CLK_DIV_PROG_SYNC_LOAD_EN`.
- Defined (glitch-free update):
  - `div_load` sets `div_nxt` <= `div_in` and `pend` <= 1.
  - Repeated loads while `pend`=1 overwrite `div_nxt`; the last load wins.
  - The pending divisor is applied on the edge where `pend`=1 and any of these holds: (`en`=1 and `cnt`==`div_cur`-1), `div_cur` < 2, or `en`=0. That edge clears `pend`.
  - If `div_load` arrives on the same edge as an apply, the old `div_nxt` is applied, `div_in` becomes the new pending value, and `pend` stays 1.
  - `clk_out` never shows a truncated period.
- Undefined (immediate update):
  - `div_load` applies `div_in` on that same edge, regardless of `en` or counter phase.
  - `pend` is tied to 0 and `div_nxt` is not implemented.

## Test plan
- Reset, then `en`=1, N=`RST_DIV`=2 for 8 cycles -> `clk_out` 0,1,0,1,0,1,0,1 and `tick` the same; `div_cur`=2.
- Load N=5 with `en`=1 -> per period, `clk_out` 0,0,0,1,1 and `tick` 0,0,0,0,1. Drop `en` for 3 cycles mid-period -> `cnt`/`clk_out` frozen, `tick`=0, then the pattern resumes without a phase loss.
- Macro defined, N=6, load N=3 at `cnt`=1 -> `pend`=1 until the edge after `cnt`=5, then `div_cur`=3 and `pend`=0. Period 6 completes intact, then periods of 3 follow.
- Macro undefined, same stimulus -> `div_cur`=3, `cnt`=0, `clk_out`=0 on the load edge; `pend` is always 0.
- Assert `rst` for 1 cycle mid-period with N=7 -> next cycle `clk_out`=0, `tick`=0, `div_cur`=2, `pend`=0.
- WIDTH=8, N=255 -> `clk_out` low for 128 cycles and high for 127, `tick` every 255 cycles. N=1 -> `tick`=1 every cycle, `clk_out`=0. N=0 -> all outputs 0.
